// File: rtl/compound_gate_pkg.sv
// compound_gate_pkg: shared definitions for compound_gate_pipe.
//   MODE_* : 2-bit function-select encodings for the MODE port.
//   eval_gate() : per-bit evaluation of the selected compound gate.
package compound_gate_pkg;

    localparam logic [1:0] MODE_OAI22 = 2'd0;
    localparam logic [1:0] MODE_AOI22 = 2'd1;
    localparam logic [1:0] MODE_OA22  = 2'd2;
    localparam logic [1:0] MODE_AO22  = 2'd3;

    // One result bit from one bit of each operand.
    function automatic logic eval_gate(input logic [1:0] mode, input logic a, input logic b,
                                       input logic c, input logic d);
        logic or_or;
        logic and_and;
        logic res;
        or_or   = (a | b) & (c | d);
        and_and = (a & b) | (c & d);
        case (mode)
            MODE_OAI22: res = ~or_or;
            MODE_AOI22: res = ~and_and;
            MODE_OA22:  res = or_or;
            default:    res = and_and;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/compound_gate_stage.sv
// compound_gate_stage: one valid/payload slot of the pipeline.
//   clk_i, rst_ni  : clock and synchronous active-low reset
//   up_valid_i     : the slot upstream (or the input) holds a beat
//   up_data_i      : payload offered by upstream
//   down_ready_i   : the slot downstream can take this slot's beat this cycle
//   valid_o/data_o : this slot's contents
module compound_gate_stage
    import compound_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             down_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             load;

    // Empty slots always load, so bubbles collapse even under a downstream stall.
    assign load = !valid_q || down_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= up_valid_i;
            // Payload only moves with a real beat, so Y stays put once drained.
            if (up_valid_i) begin
                data_q <= up_data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/compound_gate_pipe.sv
// compound_gate_pipe: valid/ready pipeline evaluating a per-bit compound gate
// (OAI22/AOI22/OA22/AO22 chosen by MODE) over A..D, DEPTH stages deep.
//   CLK, R               : clock and synchronous active-low reset
//   IN_VALID, IN_READY   : input handshake; A, B, C, D, MODE sampled on transfer
//   OUT_VALID, OUT_READY : output handshake; Y is the result
//   OUT_CNT              : wrapping count of output transfers
module compound_gate_pipe
    import compound_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic [CNT_W-1:0] OUT_CNT
);

    logic [WIDTH-1:0] gate_y;
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    // space[k]: stage k can take a beat this cycle; space[DEPTH] is the sink.
    logic [DEPTH:0]   space;
    logic [CNT_W-1:0] out_cnt_q;

    always_comb begin
        gate_y = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            gate_y[i] = eval_gate(MODE, A[i], B[i], C[i], D[i]);
        end
    end

    // Built from registered valid bits only, so IN_READY has no path from IN_VALID.
    always_comb begin
        space        = '0;
        space[DEPTH] = OUT_READY;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            space[k] = !stage_valid[k] || space[k+1];
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = IN_VALID;
            assign up_data  = gate_y;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        compound_gate_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i       (CLK),
            .rst_ni      (R),
            .up_valid_i  (up_valid),
            .up_data_i   (up_data),
            .down_ready_i(space[k+1]),
            .valid_o     (stage_valid[k]),
            .data_o      (stage_data[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            out_cnt_q <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
    end

    assign IN_READY  = R && space[0];
    assign OUT_VALID = stage_valid[DEPTH-1];
    assign Y         = stage_data[DEPTH-1];
    assign OUT_CNT   = out_cnt_q;

endmodule

// File: tb/tb_compound_gate_pipe.sv
module tb_compound_gate_pipe;

    localparam int W  = 4;
    localparam int DP = 2;
    localparam int CW = 4;
    localparam int NV = 8;

    logic          CLK = 1'b0;
    logic          R;
    logic          IN_VALID;
    logic          IN_READY;
    logic [W-1:0]  A, B, C, D;
    logic [1:0]    MODE;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [W-1:0]  Y;
    logic [CW-1:0] OUT_CNT;

    always #5 CLK = ~CLK;

    compound_gate_pipe #(
        .WIDTH(W),
        .DEPTH(DP),
        .CNT_W(CW)
    ) dut (
        .CLK      (CLK),
        .R        (R),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .MODE     (MODE),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Y        (Y),
        .OUT_CNT  (OUT_CNT)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a, b, c, d;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_err    = 0;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: the four compound gates applied to whole vectors.
    function automatic logic [W-1:0] ref_y(input logic [1:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c,
                                           input logic [W-1:0] d);
        case (m)
            2'd0:    return ~((a | b) & (c | d));
            2'd1:    return ~((a & b) | (c & d));
            2'd2:    return (a | b) & (c | d);
            default: return (a & b) | (c & d);
        endcase
    endfunction

    // Beat whose AO22 result equals v.
    task automatic drive_pass(input int v);
        MODE = 2'd3;
        A    = W'(v);
        B    = '1;
        C    = '0;
        D    = '0;
    endtask

    task automatic drive_rand();
        MODE = 2'($urandom);
        A    = W'($urandom);
        B    = W'($urandom);
        C    = W'($urandom);
        D    = W'($urandom);
    endtask

    // Account for the transfer (or reset) at the coming edge, then move past it.
    task automatic step();
        if (!R) exp_cnt = 0;
        else if (OUT_VALID && OUT_READY) exp_cnt++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            next_in, next_out, n_out;
        bit            started, prev_stall, xfer;
        logic [W-1:0]  prev_y;
        logic [W-1:0]  q [$];

        vecs[0] = '{2'd0, 4'b0011, 4'b0101, 4'b1100, 4'b0000, 4'b1011};
        vecs[1] = '{2'd1, 4'b1111, 4'b1010, 4'b0000, 4'b0110, 4'b0101};
        vecs[2] = '{2'd3, 4'b1111, 4'b1010, 4'b0000, 4'b0110, 4'b1010};
        vecs[3] = '{2'd2, 4'b1111, 4'b1010, 4'b0000, 4'b0110, 4'b0110};
        vecs[4] = '{2'd0, 4'b1111, 4'b1010, 4'b0000, 4'b0110, 4'b1001};
        vecs[5] = '{2'd2, 4'b0011, 4'b0101, 4'b1100, 4'b0000, 4'b0100};
        vecs[6] = '{2'd1, 4'b0011, 4'b0101, 4'b1100, 4'b0000, 4'b1110};
        vecs[7] = '{2'd3, 4'b0011, 4'b0101, 4'b1100, 4'b0000, 4'b0001};

        // Reset
        R = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        drive_rand();
        step();
        check("rst_in_ready_low", 32'(IN_READY), 0);
        step();
        R = 1'b1;
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 0);
        check("rst_y", 32'(Y), 0);
        check("rst_cnt", 32'(OUT_CNT), 0);
        check("rst_in_ready", 32'(IN_READY), 1);

        // Vector table streamed back-to-back: exact latency, one result per cycle
        OUT_READY = 1'b1;
        for (int t = 0; t < NV + DP; t++) begin
            if (t < NV) begin
                IN_VALID = 1'b1;
                MODE = vecs[t].mode; A = vecs[t].a; B = vecs[t].b; C = vecs[t].c; D = vecs[t].d;
            end else begin
                IN_VALID = 1'b0;
                drive_rand();
            end
            #1;
            check("tbl_in_ready", 32'(IN_READY), 1);
            if (t >= DP) begin
                check("tbl_valid", 32'(OUT_VALID), 1);
                check("tbl_y", 32'(Y), 32'(vecs[t-DP].y));
            end else begin
                check("tbl_valid_early", 32'(OUT_VALID), 0);
            end
            check("tbl_cnt", 32'(OUT_CNT), 32'(exp_cnt % 16));
            step();
        end

        // Stall: only DEPTH beats fit, then stream out in order without gaps
        OUT_READY = 1'b0;
        next_in   = 1;
        for (int t = 0; t < 4; t++) begin
            IN_VALID = 1'b1;
            drive_pass(next_in);
            #1;
            check("stall_in_ready", 32'(IN_READY), 32'(t < DP));
            if (IN_READY) next_in++;
            step();
        end
        OUT_READY = 1'b1;
        next_out  = 1;
        started   = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (next_in <= 4) begin
                IN_VALID = 1'b1;
                drive_pass(next_in);
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (t == 0) check("full_pass_in_ready", 32'(IN_READY), 1);
            if (OUT_VALID) begin
                check("stream_y", 32'(Y), 32'(next_out));
                next_out++;
                started = 1'b1;
            end else if (started && next_out <= 4) begin
                check("stream_gap", 32'(OUT_VALID), 1);
            end
            if (IN_VALID && IN_READY) next_in++;
            step();
        end
        check("stream_all_out", 32'(next_out), 5);

        // Full pipe: one in and one out on the same edge keeps occupancy at DEPTH
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        drive_pass(5); step();
        drive_pass(6); step();
        OUT_READY = 1'b1;
        drive_pass(7);
        #1;
        check("swap_in_ready", 32'(IN_READY), 1);
        check("swap_out_valid", 32'(OUT_VALID), 1);
        check("swap_y", 32'(Y), 5);
        step();
        OUT_READY = 1'b0;
        drive_pass(8);
        #1;
        check("swap_still_full", 32'(IN_READY), 0);
        check("swap_y_next", 32'(Y), 6);
        step();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        #1;
        check("swap_drain_6", 32'(Y), 6);
        step();
        check("swap_drain_7", 32'(Y), 7);
        step();
        check("swap_empty", 32'(OUT_VALID), 0);

        // Mid-operation reset discards in-flight beats
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        drive_pass(9);  step();
        drive_pass(10); step();
        R = 1'b0;
        OUT_READY = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(IN_READY), 0);
        step();
        R = 1'b1;
        IN_VALID = 1'b0;
        #1;
        check("mid_rst_valid", 32'(OUT_VALID), 0);
        check("mid_rst_y", 32'(Y), 0);
        check("mid_rst_cnt", 32'(OUT_CNT), 0);
        check("mid_rst_in_ready", 32'(IN_READY), 1);
        for (int t = 0; t < 4; t++) begin
            step();
            check("discarded_emerge", 32'(OUT_VALID), 0);
        end

        // Counter wrap: 17 transfers after reset read 15, 0, 1
        n_out = 0;
        for (int t = 0; t < 40 && n_out < 17; t++) begin
            IN_VALID  = 1'b1;
            OUT_READY = 1'b1;
            drive_rand();
            #1;
            xfer = OUT_VALID && OUT_READY;
            step();
            if (xfer) begin
                n_out++;
                if (n_out == 15) check("cnt_15", 32'(OUT_CNT), 15);
                if (n_out == 16) check("cnt_wrap", 32'(OUT_CNT), 0);
                if (n_out == 17) check("cnt_after_wrap", 32'(OUT_CNT), 1);
            end
        end
        check("cnt_transfers_done", 32'(n_out), 17);
        IN_VALID = 1'b0;
        for (int t = 0; t < 3; t++) step();
        check("cnt_model", 32'(OUT_CNT), 32'(exp_cnt % 16));

        // Randomized traffic against a queue model
        prev_stall = 1'b0;
        prev_y     = '0;
        for (int t = 0; t < 400; t++) begin
            IN_VALID  = ($urandom % 4) != 0;
            OUT_READY = ($urandom % 5) < 3;
            drive_rand();
            #1;
            check("rnd_in_ready", 32'(IN_READY), 32'((q.size() < DP) || OUT_READY));
            check("rnd_cnt", 32'(OUT_CNT), 32'(exp_cnt % 16));
            if (prev_stall) begin
                check("rnd_hold_valid", 32'(OUT_VALID), 1);
                check("rnd_hold_y", 32'(Y), 32'(prev_y));
            end
            if (OUT_VALID) begin
                if (q.size() == 0) check("rnd_spurious", 32'(OUT_VALID), 0);
                else check("rnd_y", 32'(Y), 32'(q[0]));
            end
            if (OUT_VALID && OUT_READY && q.size() > 0) void'(q.pop_front());
            if (IN_VALID && IN_READY) q.push_back(ref_y(MODE, A, B, C, D));
            prev_stall = OUT_VALID && !OUT_READY;
            prev_y     = Y;
            step();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int t = 0; t < 10; t++) begin
            #1;
            if (OUT_VALID && q.size() > 0) begin
                check("rnd_drain_y", 32'(Y), 32'(q[0]));
                void'(q.pop_front());
            end
            step();
        end
        check("rnd_drained", 32'(q.size()), 0);
        check("rnd_final_cnt", 32'(OUT_CNT), 32'(exp_cnt % 16));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/compound_gate_pipe.md
COMPOUND_GATE_PIPE -- requirements
Module: compound_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the per-input and output vector width (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of pipeline stages (legal range 1..4).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the transfer-counter width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port R, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: the upstream beat is valid.
REQ-007 The block SHALL have port IN_READY, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have ports A, B, C and D, each input, WIDTH bits: the operand vectors.
REQ-009 The block SHALL have port MODE, input, 2 bits: the per-beat function select.
REQ-010 The block SHALL have port OUT_VALID, output, 1 bit: Y holds a valid result.
REQ-011 The block SHALL have port OUT_READY, input, 1 bit: downstream accepts Y.
REQ-012 The block SHALL have port Y, output, WIDTH bits: the result vector.
REQ-013 The block SHALL have port OUT_CNT, output, CNT_W bits: the count of completed output transfers.

Function
REQ-014 Per bit, the result SHALL be: MODE=0 OAI22 ~((A|B)&(C|D)); MODE=1 AOI22 ~((A&B)|(C&D)); MODE=2 OA22 (A|B)&(C|D); MODE=3 AO22 (A&B)|(C&D).
REQ-015 An input transfer SHALL occur when IN_VALID and IN_READY are both 1 on a rising CLK edge.
REQ-016 MODE and A..D SHALL be sampled only at an input transfer; later changes SHALL not affect accepted beats.
REQ-017 An output transfer SHALL occur when OUT_VALID and OUT_READY are both 1 on a rising CLK edge.
REQ-018 Each stage SHALL hold one valid bit and a WIDTH-bit payload.
REQ-019 The result SHALL be computed combinationally before stage 0 and registered into stage 0.
REQ-020 Stages 1..DEPTH-1 SHALL pass the payload through unchanged.
REQ-021 Stage k SHALL load from stage k-1 (stage 0 from the input) when stage k is empty or stage k advances in the same cycle.
REQ-022 Bubbles SHALL collapse: an empty stage SHALL fill even while downstream is stalled.
REQ-023 IN_READY SHALL equal (stage 0 empty) OR (stage 0 advancing); it is combinational, with no path from IN_VALID.
REQ-024 OUT_VALID and Y SHALL come directly from the last stage's valid bit and payload.
REQ-025 Y SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 With OUT_READY held at 1, latency from input transfer to OUT_VALID SHALL be exactly DEPTH cycles, at a throughput of 1 beat per cycle.
REQ-027 When full and stalled, the block SHALL hold exactly DEPTH beats; no beat SHALL be lost or duplicated, and order SHALL be preserved.
REQ-028 A simultaneous input and output transfer while full SHALL be accepted, and occupancy SHALL be unchanged.
REQ-029 OUT_CNT SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-030 While R=0 at a rising edge, all stage valid bits SHALL clear, all payloads SHALL clear to 0 and OUT_CNT SHALL clear to 0.
REQ-031 In the cycle after reset: OUT_VALID=0, Y=0, OUT_CNT=0 and IN_READY=1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats, and no output transfer SHALL be counted that cycle.
REQ-033 While R=0, IN_READY SHALL be 0.

Structure
REQ-034 Package compound_gate_pkg SHALL hold the MODE encodings as named constants (MODE_OAI22=0, MODE_AOI22=1, MODE_OA22=2, MODE_AO22=3) and the function-evaluation function.
REQ-035 Sub-module compound_gate_stage SHALL implement one valid/payload slot with load/advance logic, instantiated DEPTH times by generate.

Verification (WIDTH=4, DEPTH=2, CNT_W=4)
REQ-036 MODE=0, A=0011, B=0101, C=1100, D=0000, OUT_READY=1 -> Y=1011 with OUT_VALID=1 exactly 2 cycles after acceptance.
REQ-037 MODE=1, A=1111, B=1010, C=0000, D=0110 -> Y=0101; MODE=3 with same operands -> Y=1010; back-to-back issue -> 1 result per cycle.
REQ-038 OUT_READY=0, IN_VALID=1 for 4 cycles with beats 1,2,3,4 -> 2 accepted, then IN_READY=0; after OUT_READY=1, outputs appear in order 1,2,3,4 with no gaps once streaming.
REQ-039 Full pipe with OUT_READY=1 and IN_VALID=1 on the same edge -> one out, one in, occupancy stays 2, IN_READY stays 1.
REQ-040 R=0 for 1 cycle with 2 beats in flight -> next cycle OUT_VALID=0, Y=0000, OUT_CNT=0, IN_READY=1; the discarded beats never emerge.
REQ-041 17 output transfers after reset -> OUT_CNT reads 15, then 0, then 1.
